// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: synchronizes and debounces the tank-level and climate
// sensors, then runs a five-state controller that fills the tank, runs the
// sprinkler or drip line, and latches a fault on inconsistent level readings.
module irrigation_scheduler #(
  parameter int DEB_CYC = 4,
  parameter int SPR_MIN = 8,
  parameter int DRP_MIN = 16,
  parameter int FILL_TO = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Ua,
  input  logic       Us,
  input  logic       T,
  input  logic       en,
  output logic       Ve,
  output logic       Bs,
  output logic       Vs,
  output logic       Al,
  output logic       E,
  output logic [2:0] state
);

  localparam int NSENS = 6;
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [DEB_W-1:0] DEB_LIM  = DEB_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] SPR_LIM  = CNT_W'(SPR_MIN - 1);
  localparam logic [CNT_W-1:0] DRP_LIM  = CNT_W'(DRP_MIN - 1);
  localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_TO - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  // Sensor bit order: [5]=H [4]=M [3]=L [2]=Ua [1]=Us [0]=T
  logic [NSENS-1:0] w_raw;
  logic [NSENS-1:0] r_sync1;
  logic [NSENS-1:0] r_sync2;
  logic [NSENS-1:0] r_filt;
  logic [DEB_W-1:0] r_stab [NSENS];

  logic w_h, w_m, w_l, w_ua, w_us, w_t;
  logic w_err, w_drip_dem, w_spr_dem;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  assign w_raw = {H, M, L, Ua, Us, T};

  // Two-flop synchronizer for every asynchronous sensor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the filtered bit follows the synchronized bit only after it has
  // disagreed with the filtered value for DEB_CYC cycles in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < NSENS; i++) r_stab[i] <= '0;
    end else begin
      for (int i = 0; i < NSENS; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_stab[i] <= '0;
        end else if (r_stab[i] == DEB_LIM) begin
          r_filt[i] <= r_sync2[i];
          r_stab[i] <= '0;
        end else begin
          r_stab[i] <= r_stab[i] + 1'b1;
        end
      end
    end
  end

  assign w_h  = r_filt[5];
  assign w_m  = r_filt[4];
  assign w_l  = r_filt[3];
  assign w_ua = r_filt[2];
  assign w_us = r_filt[1];
  assign w_t  = r_filt[0];

  // A level sensor reporting water above a dry lower sensor is impossible,
  // so it is treated as a sensor fault. The two demands split on (Ua & T),
  // which keeps them mutually exclusive.
  assign w_err      = (w_m & ~w_l) | (w_h & ~w_m);
  assign w_drip_dem = ~w_us & w_ua & w_t;
  assign w_spr_dem  = ~w_us & ~(w_ua & w_t);

  // Next-state logic; a level fault preempts everything outside FAULT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_err)                  w_next = FAULT;
        else if (!w_m)              w_next = FILL;
        else if (en && w_spr_dem)   w_next = SPRINKLE;
        else if (en && w_drip_dem)  w_next = DRIP;
      end
      FILL: begin
        if (w_err)                  w_next = FAULT;
        else if (w_h)               w_next = IDLE;
        else if (r_cnt >= FILL_LIM) w_next = FAULT;
      end
      SPRINKLE: begin
        if (w_err)                  w_next = FAULT;
        else if (!w_l)              w_next = IDLE;
        else if ((r_cnt >= SPR_LIM) && (w_us || !en)) w_next = IDLE;
      end
      DRIP: begin
        if (w_err)                  w_next = FAULT;
        else if (!w_l)              w_next = IDLE;
        else if ((r_cnt >= DRP_LIM) && (w_us || !en)) w_next = IDLE;
      end
      FAULT: begin
        if (!en && !w_err)          w_next = IDLE;
      end
      default:                      w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Run/timeout counter: restarts on each state change, counts while an
  // actuator is active, and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (((r_state == FILL) || (r_state == SPRINKLE) || (r_state == DRIP))
                 && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Actuator flops decode the state being loaded, so they always match the
  // state register cycle for cycle while still coming straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Ve <= 1'b0;
      Bs <= 1'b0;
      Vs <= 1'b0;
      Al <= 1'b0;
      E  <= 1'b0;
    end else begin
      Ve <= (w_next == FILL);
      Bs <= (w_next == SPRINKLE);
      Vs <= (w_next == DRIP);
      Al <= (w_next == FAULT);
      E  <= (w_next == FAULT);
    end
  end

  assign state = r_state;

endmodule
